// File: rtl/rstseqctrl_pkg.sv
// ---------------------------------------------------------------------------
// rstseqctrl_pkg
//   Shared encodings for the reset/power sequencer. The cause codes are the
//   values reported on cause_o and are also what devtbl INFO readback and
//   software decode, so they must stay stable.
//   Contents:
//     cause_e       - sequence cause codes (RSQ_NONE .. RSQ_RRESET)
//     state_e       - sequencer state encodings
//     rsq_decode    - turns sampled devtbl action outputs into a cause
//     rsq_holds_dev - 1 when a cause also holds the device reset
// ---------------------------------------------------------------------------
package rstseqctrl_pkg;

  typedef enum logic [2:0] {
    RSQ_NONE   = 3'd0,
    RSQ_PWROFF = 3'd1,
    RSQ_WRESET = 3'd2,
    RSQ_CRESET = 3'd3,
    RSQ_RRESET = 3'd4
  } cause_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_HOLD   = 3'd2,
    ST_RELDEV = 3'd3,
    ST_OFF    = 3'd4
  } state_e;

  localparam logic [1:0] LVL_NONE = 2'b00;

  // A level code only counts when it differs from last cycle's level and is
  // non-zero. Level codes (PWROFF/CRESET/WRESET) outrank the RRESET pulse;
  // PWROFF and CRESET are distinct codes so they can never collide.
  function automatic cause_e rsq_decode(input logic [1:0] lvl_now,
                                        input logic [1:0] lvl_prev,
                                        input logic       rst2);
    cause_e c;
    c = RSQ_NONE;
    if ((lvl_now != lvl_prev) && (lvl_now != LVL_NONE)) begin
      case (lvl_now)
        2'b01:   c = RSQ_PWROFF;
        2'b10:   c = RSQ_WRESET;
        2'b11:   c = RSQ_CRESET;
        default: c = RSQ_NONE;
      endcase
    end else if (rst2) begin
      c = RSQ_RRESET;
    end else begin
      c = RSQ_NONE;
    end
    return c;
  endfunction

  // WRESET/RRESET keep devices (and devtbl state) alive across the sequence.
  function automatic logic rsq_holds_dev(input cause_e c);
    return (c == RSQ_PWROFF) || (c == RSQ_CRESET);
  endfunction

endpackage

// File: rtl/rstseqctrl_if.sv
// ---------------------------------------------------------------------------
// rstseqctrl_if
//   Groups the sequencer's devtbl/bus-side signals.
//   slave  (sequencer side): inputs  rst0_i, rst1_i, rst2_i, drained_i
//                            outputs busstall_o, cpurst_o, devrst_o,
//                                    pwroff_o, busy_o, cause_o, tmo_o
//   master (environment side): the same signals with directions reversed.
// ---------------------------------------------------------------------------
interface rstseqctrl_if;
  import rstseqctrl_pkg::*;

  logic   rst0_i;
  logic   rst1_i;
  logic   rst2_i;
  logic   drained_i;
  logic   busstall_o;
  logic   cpurst_o;
  logic   devrst_o;
  logic   pwroff_o;
  logic   busy_o;
  cause_e cause_o;
  logic   tmo_o;

  modport slave (
    input  rst0_i, rst1_i, rst2_i, drained_i,
    output busstall_o, cpurst_o, devrst_o, pwroff_o, busy_o, cause_o, tmo_o
  );

  modport master (
    output rst0_i, rst1_i, rst2_i, drained_i,
    input  busstall_o, cpurst_o, devrst_o, pwroff_o, busy_o, cause_o, tmo_o
  );

endinterface

// File: rtl/rstseqctrl.sv
// ---------------------------------------------------------------------------
// rstseqctrl
//   Reset/power sequencer fed by devtbl's action outputs. On an accepted event
//   it stalls the bus, waits for outstanding traffic to drain (bounded by
//   DRAINTMO), holds resets for HOLDCYC cycles, then releases devices first
//   and cores STAGEGAP cycles later. PWROFF ends in a terminal OFF state.
//   Ports:
//     clk_i   - clock
//     rstn_i  - asynchronous active-low reset (power-on runs a CRESET release)
//     bus     - rstseqctrl_if.slave: devtbl levels/pulse, drain status in;
//               stall, core/device reset, power-off, busy, cause, timeout out
//   Parameters: HOLDCYC, STAGEGAP, DRAINTMO (all >= 1).
// ---------------------------------------------------------------------------
module rstseqctrl
  import rstseqctrl_pkg::*;
#(
  parameter int HOLDCYC  = 16,
  parameter int STAGEGAP = 4,
  parameter int DRAINTMO = 1024
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  rstseqctrl_if.slave   bus
);

  localparam int MAX_HS = (HOLDCYC > STAGEGAP) ? HOLDCYC : STAGEGAP;
  localparam int MAXCYC = (MAX_HS > DRAINTMO) ? MAX_HS : DRAINTMO;
  localparam int CNTW   = $clog2(MAXCYC) + 1;

  localparam logic [CNTW-1:0] HOLD_LAST  = CNTW'(HOLDCYC - 1);
  localparam logic [CNTW-1:0] GAP_LAST   = CNTW'(STAGEGAP - 1);
  localparam logic [CNTW-1:0] DRAIN_LAST = CNTW'(DRAINTMO - 1);
  localparam logic [CNTW-1:0] CNT_MAX    = {CNTW{1'b1}};

  state_e          state_q, state_d;
  cause_e          cause_q, cause_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [1:0]      lvl_q, lvl_d;
  logic            tmo_q, tmo_d;
  logic            busstall_q, busstall_d;
  logic            cpurst_q, cpurst_d;
  logic            devrst_q, devrst_d;
  logic            pwroff_q, pwroff_d;
  logic            busy_q, busy_d;
  cause_e          evt_s;

  assign lvl_d = {bus.rst1_i, bus.rst0_i};
  assign evt_s = rsq_decode(lvl_d, lvl_q, bus.rst2_i);

  // Next-state, cause/timeout capture and phase counter.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    tmo_d   = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (evt_s != RSQ_NONE) begin
          state_d = ST_DRAIN;
          cause_d = evt_s;
          tmo_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        // A drain seen on the timeout cycle wins: no timeout is flagged.
        if (bus.drained_i) begin
          state_d = ST_HOLD;
        end else if (cnt_q == DRAIN_LAST) begin
          state_d = ST_HOLD;
          tmo_d   = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = (cause_q == RSQ_PWROFF) ? ST_OFF : ST_RELDEV;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_RELDEV: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RELDEV;
        end
      end
      ST_OFF: begin
        state_d = ST_OFF;
      end
      default: begin
        // Illegal encoding: recover through a full core+device reset.
        state_d = ST_HOLD;
        cause_d = RSQ_CRESET;
      end
    endcase

    // Counter restarts on every state entry and saturates instead of wrapping.
    if (state_d != state_q) begin
      cnt_d = {CNTW{1'b0}};
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNTW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Output decode from the next state so every output is a flop.
  always_comb begin
    busstall_d = 1'b1;
    cpurst_d   = 1'b1;
    devrst_d   = 1'b1;
    pwroff_d   = 1'b0;
    busy_d     = 1'b1;
    case (state_d)
      ST_IDLE: begin
        busstall_d = 1'b0;
        cpurst_d   = 1'b0;
        devrst_d   = 1'b0;
        busy_d     = 1'b0;
      end
      ST_DRAIN: begin
        cpurst_d = 1'b0;
        devrst_d = 1'b0;
      end
      ST_HOLD: begin
        devrst_d = rsq_holds_dev(cause_d);
      end
      ST_RELDEV: begin
        devrst_d = 1'b0;
      end
      ST_OFF: begin
        pwroff_d = 1'b1;
      end
      default: begin
        pwroff_d = 1'b0;
      end
    endcase
  end

  // State, counter, level tracker and registered outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= ST_HOLD;
      cause_q    <= RSQ_CRESET;
      cnt_q      <= {CNTW{1'b0}};
      lvl_q      <= 2'b00;
      tmo_q      <= 1'b0;
      busstall_q <= 1'b1;
      cpurst_q   <= 1'b1;
      devrst_q   <= 1'b1;
      pwroff_q   <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      cnt_q      <= cnt_d;
      lvl_q      <= lvl_d;
      tmo_q      <= tmo_d;
      busstall_q <= busstall_d;
      cpurst_q   <= cpurst_d;
      devrst_q   <= devrst_d;
      pwroff_q   <= pwroff_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.busstall_o = busstall_q;
  assign bus.cpurst_o   = cpurst_q;
  assign bus.devrst_o   = devrst_q;
  assign bus.pwroff_o   = pwroff_q;
  assign bus.busy_o     = busy_q;
  assign bus.cause_o    = cause_q;
  assign bus.tmo_o      = tmo_q;

endmodule
